// File: rtl/reset_sequencer_pkg.sv
// Shared clock/reset infrastructure definitions: sequencer state encodings,
// reset-cause codes and the state-to-reset-output decode.
package reset_sequencer_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CAUSE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_HOLD  = 3'd0,
        S_MEM   = 3'd1,
        S_IO    = 3'd2,
        S_RUN   = 3'd3,
        S_SOFT  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE  = 2'b00,
        CAUSE_POR   = 2'b01,
        CAUSE_SW    = 2'b10,
        CAUSE_FAULT = 2'b11
    } cause_t;

    // Returns {mem_rst_n, io_rst_n, cpu_rst_n} for a given state.
    function automatic logic [2:0] rst_decode(input state_t s);
        logic [2:0] r;
        r = 3'b000;
        case (s)
            S_MEM, S_SOFT: r = 3'b100;
            S_IO:          r = 3'b110;
            S_RUN:         r = 3'b111;
            default:       r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/status bundle between the reset sequencer and the domains it controls.
interface reset_sequencer_if;
    import reset_sequencer_pkg::*;

    logic   SwResetReq;
    logic   MemReady;
    logic   MemReset_n;
    logic   IoReset_n;
    logic   CpuReset_n;
    cause_t ResetCause;
    logic   Fault;

    modport master (
        input  SwResetReq,
        input  MemReady,
        output MemReset_n,
        output IoReset_n,
        output CpuReset_n,
        output ResetCause,
        output Fault
    );

    modport slave (
        output SwResetReq,
        output MemReady,
        input  MemReset_n,
        input  IoReset_n,
        input  CpuReset_n,
        input  ResetCause,
        input  Fault
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset release for memory, I/O and CPU domains, with software reset
// and a sticky fault when memory initialization never completes.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned STAGE_CYCLES   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 Clock,
    input  logic                 Reset,
    reset_sequencer_if.master    bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    cause_t           cause_q, cause_nxt;
    logic             fault_q, fault_nxt;
    logic [2:0]       rst_q, rst_nxt;

    // Next state, counter and registered-output values.
    always_comb begin
        state_nxt = state_q;
        cause_nxt = cause_q;
        fault_nxt = fault_q;
        cnt_nxt   = cnt_q;
        rst_nxt   = 3'b000;

        case (state_q)
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_nxt = S_MEM;
                    cause_nxt = CAUSE_POR;
                end
            end
            S_MEM: begin
                // Ready takes priority over a coincident timeout.
                if (bus.MemReady && (cnt_q >= STAGE_LAST)) begin
                    state_nxt = S_IO;
                end else if (cnt_q == TMO_LAST) begin
                    state_nxt = S_FAULT;
                    cause_nxt = CAUSE_FAULT;
                    fault_nxt = 1'b1;
                end
            end
            S_IO: begin
                if (cnt_q == STAGE_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.SwResetReq) begin
                    state_nxt = S_SOFT;
                    cause_nxt = CAUSE_SW;
                end
            end
            S_SOFT: begin
                if (cnt_q == HOLD_LAST) state_nxt = S_IO;
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_HOLD;
            end
        endcase

        if (state_nxt != state_q) begin
            cnt_nxt = '0;
        end else if (cnt_q != TMO_LAST) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end

        rst_nxt = rst_decode(state_nxt);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
            fault_q <= 1'b0;
            rst_q   <= 3'b000;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            cause_q <= cause_nxt;
            fault_q <= fault_nxt;
            rst_q   <= rst_nxt;
        end
    end

    assign bus.MemReset_n = rst_q[2];
    assign bus.IoReset_n  = rst_q[1];
    assign bus.CpuReset_n = rst_q[0];
    assign bus.ResetCause = cause_q;
    assign bus.Fault      = fault_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with HOLD=4, STAGE=3, TIMEOUT=16.
module tb_reset_sequencer;
    import reset_sequencer_pkg::*;

    logic Clock;
    logic Reset;
    int   n_checks;
    int   n_fail;

    reset_sequencer_if bus ();

    reset_sequencer #(
        .HOLD_CYCLES    (4),
        .STAGE_CYCLES   (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Hold Reset low briefly and release it between edges; next posedge is edge 1.
    task automatic release_reset();
        @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000",
                     {bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n});
        end
        n_checks++;
        if (bus.ResetCause !== 2'b00 || bus.Fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got cause=%b fault=%b expected 00/0",
                     bus.ResetCause, bus.Fault);
        end
    endtask

    task automatic test_power_on(input string tag);
        bus.MemReady = 1'b1;
        release_reset();
        tick(3);
        n_checks++;
        if (bus.MemReset_n !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_mem_edge3: got %b expected 0", tag, bus.MemReset_n);
        end
        tick(1);
        n_checks++;
        if (bus.MemReset_n !== 1'b1 || bus.IoReset_n !== 1'b0 || bus.ResetCause !== 2'b01) begin
            n_fail++;
            $display("FAIL %s_edge4: got mem=%b io=%b cause=%b expected 1/0/01",
                     tag, bus.MemReset_n, bus.IoReset_n, bus.ResetCause);
        end
        tick(2);
        n_checks++;
        if (bus.IoReset_n !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_io_edge6: got %b expected 0", tag, bus.IoReset_n);
        end
        tick(1);
        n_checks++;
        if (bus.IoReset_n !== 1'b1 || bus.CpuReset_n !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_edge7: got io=%b cpu=%b expected 1/0",
                     tag, bus.IoReset_n, bus.CpuReset_n);
        end
        tick(2);
        n_checks++;
        if (bus.CpuReset_n !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_cpu_edge9: got %b expected 0", tag, bus.CpuReset_n);
        end
        tick(1);
        n_checks++;
        if ({bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n} !== 3'b111 ||
            bus.ResetCause !== 2'b01 || bus.Fault !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_edge10: got rst=%b cause=%b fault=%b expected 111/01/0", tag,
                     {bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n}, bus.ResetCause, bus.Fault);
        end
    endtask

    task automatic test_late_mem();
        bus.MemReady = 1'b0;
        release_reset();
        tick(13);
        n_checks++;
        if (bus.MemReset_n !== 1'b1 || bus.IoReset_n !== 1'b0) begin
            n_fail++;
            $display("FAIL late_wait: got mem=%b io=%b expected 1/0",
                     bus.MemReset_n, bus.IoReset_n);
        end
        bus.MemReady = 1'b1;
        tick(1);
        n_checks++;
        if (bus.IoReset_n !== 1'b1 || bus.CpuReset_n !== 1'b0) begin
            n_fail++;
            $display("FAIL late_io: got io=%b cpu=%b expected 1/0",
                     bus.IoReset_n, bus.CpuReset_n);
        end
        tick(2);
        n_checks++;
        if (bus.CpuReset_n !== 1'b0) begin
            n_fail++;
            $display("FAIL late_cpu_early: got %b expected 0", bus.CpuReset_n);
        end
        tick(1);
        n_checks++;
        if (bus.CpuReset_n !== 1'b1) begin
            n_fail++;
            $display("FAIL late_cpu: got %b expected 1", bus.CpuReset_n);
        end
    endtask

    task automatic test_timeout();
        bus.MemReady = 1'b0;
        release_reset();
        tick(19);
        n_checks++;
        if (bus.MemReset_n !== 1'b1 || bus.Fault !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pre: got mem=%b fault=%b expected 1/0",
                     bus.MemReset_n, bus.Fault);
        end
        tick(1);
        n_checks++;
        if ({bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n} !== 3'b000 ||
            bus.Fault !== 1'b1 || bus.ResetCause !== 2'b11) begin
            n_fail++;
            $display("FAIL timeout_fault: got rst=%b fault=%b cause=%b expected 000/1/11",
                     {bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n}, bus.Fault, bus.ResetCause);
        end
        bus.SwResetReq = 1'b1;
        bus.MemReady   = 1'b1;
        tick(6);
        n_checks++;
        if ({bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n} !== 3'b000 ||
            bus.Fault !== 1'b1 || bus.ResetCause !== 2'b11) begin
            n_fail++;
            $display("FAIL timeout_sticky: got rst=%b fault=%b cause=%b expected 000/1/11",
                     {bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n}, bus.Fault, bus.ResetCause);
        end
        bus.SwResetReq = 1'b0;
        Reset = 1'b0;
        #1;
        n_checks++;
        if (bus.Fault !== 1'b0 || bus.ResetCause !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_clear: got fault=%b cause=%b expected 0/00",
                     bus.Fault, bus.ResetCause);
        end
    endtask

    task automatic test_boundary();
        bus.MemReady = 1'b0;
        release_reset();
        tick(19);
        bus.MemReady = 1'b1;
        tick(1);
        n_checks++;
        if (bus.IoReset_n !== 1'b1 || bus.MemReset_n !== 1'b1 ||
            bus.Fault !== 1'b0 || bus.ResetCause !== 2'b01) begin
            n_fail++;
            $display("FAIL boundary: got mem=%b io=%b fault=%b cause=%b expected 1/1/0/01",
                     bus.MemReset_n, bus.IoReset_n, bus.Fault, bus.ResetCause);
        end
    endtask

    // Starts in S_RUN; memory-ready drop during the sequence must be ignored.
    task automatic test_soft_reset();
        bus.SwResetReq = 1'b1;
        tick(1);
        bus.SwResetReq = 1'b0;
        bus.MemReady   = 1'b0;
        n_checks++;
        if ({bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n} !== 3'b100 ||
            bus.ResetCause !== 2'b10) begin
            n_fail++;
            $display("FAIL soft_enter: got rst=%b cause=%b expected 100/10",
                     {bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n}, bus.ResetCause);
        end
        tick(3);
        n_checks++;
        if (bus.IoReset_n !== 1'b0) begin
            n_fail++;
            $display("FAIL soft_io_early: got %b expected 0", bus.IoReset_n);
        end
        tick(1);
        n_checks++;
        if (bus.IoReset_n !== 1'b1 || bus.CpuReset_n !== 1'b0 || bus.MemReset_n !== 1'b1) begin
            n_fail++;
            $display("FAIL soft_io: got mem=%b io=%b cpu=%b expected 1/1/0",
                     bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n);
        end
        tick(2);
        n_checks++;
        if (bus.CpuReset_n !== 1'b0) begin
            n_fail++;
            $display("FAIL soft_cpu_early: got %b expected 0", bus.CpuReset_n);
        end
        tick(1);
        n_checks++;
        if (bus.CpuReset_n !== 1'b1 || bus.ResetCause !== 2'b10) begin
            n_fail++;
            $display("FAIL soft_cpu: got cpu=%b cause=%b expected 1/10",
                     bus.CpuReset_n, bus.ResetCause);
        end
    endtask

    // Request held high retriggers as soon as S_RUN is re-entered.
    task automatic test_back_to_back();
        bus.SwResetReq = 1'b1;
        tick(1);
        n_checks++;
        if (bus.CpuReset_n !== 1'b0 || bus.IoReset_n !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: got io=%b cpu=%b expected 0/0",
                     bus.IoReset_n, bus.CpuReset_n);
        end
        tick(7);
        n_checks++;
        if ({bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n} !== 3'b111) begin
            n_fail++;
            $display("FAIL b2b_run: got %b expected 111",
                     {bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n});
        end
        tick(1);
        n_checks++;
        if ({bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_retrigger: got %b expected 100",
                     {bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n});
        end
        bus.SwResetReq = 1'b0;
    endtask

    task automatic test_abort();
        bus.MemReady = 1'b1;
        release_reset();
        tick(8);
        n_checks++;
        if ({bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n} !== 3'b110) begin
            n_fail++;
            $display("FAIL abort_in_io: got %b expected 110",
                     {bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n});
        end
        #2;
        Reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n} !== 3'b000 ||
            bus.ResetCause !== 2'b00 || bus.Fault !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: got rst=%b cause=%b fault=%b expected 000/00/0",
                     {bus.MemReset_n, bus.IoReset_n, bus.CpuReset_n}, bus.ResetCause, bus.Fault);
        end
        test_power_on("abort_rerun");
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        Reset          = 1'b0;
        bus.SwResetReq = 1'b0;
        bus.MemReady   = 1'b0;
        tick(2);
        test_reset();
        test_power_on("por");
        test_soft_reset();
        test_back_to_back();
        test_late_mem();
        test_timeout();
        test_boundary();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
